program_counter_stack: RTL and testbench
========================================

// Module: program_counter_stack
// PURPOSE
//   Parametrised successor to the team's 2-bit-select program counter. Adds configurable width and
//   step, a flag-conditional relative branch, and a hardware return-address stack for CALL/RET.
//   Sits in the fetch stage: drives the instruction address and takes its select from the decoder.
//   Takes its branch condition from the ALU status flags.
// PARAMETERS
//   WIDTH      32  PC / PC_IN width in bits
//   STEP        1  increment applied by INC and by a not-taken BCOND (added modulo 2^WIDTH)
//   DEPTH       4  return-stack entries, >=2
//   RESET_VEC   0  PC_OUT value after reset
// PORTS
//   clock     in   1                  rising-edge clock
//   reset     in   1                  asynchronous, active-low reset (0 = in reset)
//   PS        in   3                  operation select (see BEHAVIOUR)
//   PC_IN     in   WIDTH              absolute target (JUMP/CALL) or two's-complement offset (BREL/BCOND)
//   cond      in   3                  BCOND condition code
//   status    in   4                  ALU flags {N,Z,C,V}
//   stall     in   1                  1 = freeze PC, stack and flags this cycle
//   PC_OUT    out  WIDTH              current program counter
//   taken     out  1                  registered: last executed op redirected the PC
//   sp        out  $clog2(DEPTH+1)    stack occupancy, 0..DEPTH
//   overflow  out  1                  sticky: CALL issued with the stack full
//   underflow out  1                  sticky: RET issued with the stack empty
// BEHAVIOUR
//   Reset (async assert, sync release): PC_OUT=RESET_VEC; sp, taken, overflow, underflow = 0.
//     Stack contents are don't-care. Reset mid-operation discards any in-flight push or pop.
//   All updates occur on the rising clock edge. Latency is 1 cycle: PC_OUT shows the new value
//     in the cycle after PS is sampled.
//   stall=1: every register holds, whatever PS is. taken holds its previous value.
//   PS encodings (PC = PC_OUT; all arithmetic mod 2^WIDTH; wrap-around is silent):
//     000 HOLD   PC<=PC                                                      taken=0
//     001 INC    PC<=PC+STEP                                                 taken=0
//     010 JUMP   PC<=PC_IN                                                   taken=1
//     011 BREL   PC<=PC+PC_IN                                                taken=1
//     100 BCOND  if cond true: PC<=PC+PC_IN, taken=1; else PC<=PC+STEP, taken=0
//     101 CALL   push PC+STEP; PC<=PC_IN; sp++                               taken=1
//     110 RET    pop top-of-stack into PC; sp--                              taken=1
//     111 rsvd   treated as HOLD, taken=0
//   cond codes: 0 EQ Z, 1 NE !Z, 2 CS C, 3 CC !C, 4 MI N, 5 PL !N, 6 VS V, 7 GE N==V.
//     status is sampled in the same cycle as PS.
//   CALL when sp==DEPTH: the push is dropped, PC<=PC_IN still occurs, sp stays DEPTH, overflow<=1.
//   RET when sp==0: PC holds, taken=0, underflow<=1.
//   overflow and underflow clear only on reset.
//   The stack is LIFO. A RET returns the most recent push. sp never leaves the range 0..DEPTH.
// STRUCTURE
//   Package pc_pkg: PS opcode localparams (PS_HOLD..PS_RET) and cond-code localparams (CC_EQ..CC_GE).
//   Sub-module return_stack #(WIDTH,DEPTH): ports push, pop, din, dout, sp, full, empty.
//     Register array plus pointer; push and pop are never asserted together.
//   Top level: condition evaluator, next-PC mux, flag registers.
// TESTING
//   1. Reset low for 2 cycles, then release -> PC_OUT=0, sp=0, overflow=0, underflow=0.
//      Then stall=1 with PS=INC -> PC unchanged.
//   2. INC x3, JUMP PC_IN=100, BREL PC_IN=-4 -> PC_OUT sequence 1,2,3,100,96; taken 0,0,0,1,1.
//   3. At PC=10: BCOND EQ with Z=1, PC_IN=6 -> 16, taken=1.
//      Then BCOND GE with N=1, V=0 -> 17, taken=0.
//   4. At PC=20: CALL 200, CALL 300, RET, RET -> PC 200,300,201,21; sp 1,2,1,0.
//   5. DEPTH=4: five CALLs -> sp=4, overflow=1, and PC tracks every target.
//      Four RETs return the four stored addresses. A fifth RET -> PC holds, underflow=1.
//   6. PC=32'hFFFF_FFFF with INC -> 0. Reset asserted mid-CALL sequence -> PC=RESET_VEC and sp=0 immediately.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared opcode and condition-code constants for the fetch-stage program counter.
// Also holds the flag-condition evaluator.
package pc_pkg;

    localparam logic [2:0] PS_HOLD  = 3'd0;
    localparam logic [2:0] PS_INC   = 3'd1;
    localparam logic [2:0] PS_JUMP  = 3'd2;
    localparam logic [2:0] PS_BREL  = 3'd3;
    localparam logic [2:0] PS_BCOND = 3'd4;
    localparam logic [2:0] PS_CALL  = 3'd5;
    localparam logic [2:0] PS_RET   = 3'd6;
    localparam logic [2:0] PS_RSVD  = 3'd7;

    localparam logic [2:0] CC_EQ = 3'd0;
    localparam logic [2:0] CC_NE = 3'd1;
    localparam logic [2:0] CC_CS = 3'd2;
    localparam logic [2:0] CC_CC = 3'd3;
    localparam logic [2:0] CC_MI = 3'd4;
    localparam logic [2:0] CC_PL = 3'd5;
    localparam logic [2:0] CC_VS = 3'd6;
    localparam logic [2:0] CC_GE = 3'd7;

    // flags are packed {N,Z,C,V}
    function automatic logic cond_met(input logic [2:0] cc, input logic [3:0] flags);
        logic n, z, c, v;
        logic res;
        n   = flags[3];
        z   = flags[2];
        c   = flags[1];
        v   = flags[0];
        res = 1'b0;
        case (cc)
            CC_EQ:   res = z;
            CC_NE:   res = !z;
            CC_CS:   res = c;
            CC_CC:   res = !c;
            CC_MI:   res = n;
            CC_PL:   res = !n;
            CC_VS:   res = v;
            default: res = (n == v);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses: register array indexed by an occupancy pointer.
// Push when full and pop when empty are ignored; the caller flags those cases.
module return_stack #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned SPW  = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [SPW-1:0]   sp,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]   sp_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (sp_q == SPW'(DEPTH));
    assign empty   = (sp_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign sp      = sp_q;
    assign dout    = empty ? '0 : mem_q[AW'(sp_q - SPW'(1))];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp_q <= '0;
        end else if (do_push) begin
            sp_q <= sp_q + SPW'(1);
        end else if (do_pop) begin
            sp_q <= sp_q - SPW'(1);
        end
    end

    // Contents need no reset: only entries below sp are ever read.
    always_ff @(posedge clock) begin
        if (reset && do_push) begin
            mem_q[AW'(sp_q)] <= din;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// Fetch-stage program counter with step increment, relative/conditional branches
// and a hardware return-address stack for CALL/RET.
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     STEP      = 1,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    localparam int unsigned    SPW       = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       PS,
    input  logic [WIDTH-1:0] PC_IN,
    input  logic [2:0]       cond,
    input  logic [3:0]       status,
    input  logic             stall,
    output logic [WIDTH-1:0] PC_OUT,
    output logic             taken,
    output logic [SPW-1:0]   sp,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             taken_q, taken_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push, pop;
    logic [WIDTH-1:0] pc_step;
    logic [WIDTH-1:0] pc_rel;
    logic [WIDTH-1:0] ret_addr;
    logic             full, empty;

    assign pc_step = pc_q + WIDTH'(STEP);
    assign pc_rel  = pc_q + PC_IN;

    return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_step),
        .dout  (ret_addr),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        pc_d    = pc_q;
        taken_d = taken_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (!stall) begin
            taken_d = 1'b0;
            case (PS)
                PS_INC: pc_d = pc_step;
                PS_JUMP: begin
                    pc_d    = PC_IN;
                    taken_d = 1'b1;
                end
                PS_BREL: begin
                    pc_d    = pc_rel;
                    taken_d = 1'b1;
                end
                PS_BCOND: begin
                    taken_d = cond_met(cond, status);
                    pc_d    = taken_d ? pc_rel : pc_step;
                end
                PS_CALL: begin
                    // The jump still happens when the push is dropped.
                    pc_d    = PC_IN;
                    taken_d = 1'b1;
                    push    = 1'b1;
                    if (full) ovf_d = 1'b1;
                end
                PS_RET: begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        pc_d    = ret_addr;
                        taken_d = 1'b1;
                        pop     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_VEC;
            taken_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign PC_OUT    = pc_q;
    assign taken     = taken_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack: a queue-based reference model checked every
// cycle, plus literal expectations after each directed operation.
module tb_program_counter_stack;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SPW   = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [2:0]       PS = 3'd0;
    logic [WIDTH-1:0] PC_IN = '0;
    logic [2:0]       cond = 3'd0;
    logic [3:0]       status = 4'd0;
    logic             stall = 1'b0;
    logic [WIDTH-1:0] PC_OUT;
    logic             taken;
    logic [SPW-1:0]   sp;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [31:0] m_pc = '0;
    bit          m_taken = 0;
    bit          m_ovf = 0;
    bit          m_unf = 0;
    logic [31:0] m_stack[$];

    program_counter_stack #(
        .WIDTH     (WIDTH),
        .STEP      (1),
        .DEPTH     (DEPTH),
        .RESET_VEC ('0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .PS        (PS),
        .PC_IN     (PC_IN),
        .cond      (cond),
        .status    (status),
        .stall     (stall),
        .PC_OUT    (PC_OUT),
        .taken     (taken),
        .sp        (sp),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic bit flag_cond(input logic [2:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return cy;
            3'd3: return !cy;
            3'd4: return n;
            3'd5: return !n;
            3'd6: return v;
            default: return n == v;
        endcase
    endfunction

    // Reference model and per-cycle compare.
    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_pc = 0; m_taken = 0; m_ovf = 0; m_unf = 0;
                m_stack.delete();
            end else if (!stall) begin
                m_taken = 0;
                case (PS)
                    3'd1: m_pc = m_pc + 1;
                    3'd2: begin m_pc = PC_IN; m_taken = 1; end
                    3'd3: begin m_pc = m_pc + PC_IN; m_taken = 1; end
                    3'd4: begin
                        m_taken = flag_cond(cond, status);
                        m_pc = m_taken ? m_pc + PC_IN : m_pc + 1;
                    end
                    3'd5: begin
                        if (m_stack.size() < DEPTH) m_stack.push_back(m_pc + 1);
                        else m_ovf = 1;
                        m_pc = PC_IN;
                        m_taken = 1;
                    end
                    3'd6: begin
                        if (m_stack.size() == 0) m_unf = 1;
                        else begin m_pc = m_stack.pop_back(); m_taken = 1; end
                    end
                    default: ;
                endcase
            end
            #1;
            check("model_pc", PC_OUT, m_pc);
            check("model_taken", {31'd0, taken}, {31'd0, m_taken});
            check("model_sp", {{(32-SPW){1'b0}}, sp}, m_stack.size());
            check("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
            check("model_underflow", {31'd0, underflow}, {31'd0, m_unf});
        end
    end

    task automatic op(input logic [2:0] ps, input logic [31:0] pin,
                      input logic [2:0] cc = 3'd0, input logic [3:0] st = 4'd0,
                      input logic stl = 1'b0);
        @(negedge clock);
        PS = ps; PC_IN = pin; cond = cc; status = st; stall = stl;
        @(posedge clock);
        #2;
    endtask

    initial begin
        // 1. reset and stall
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("reset_pc", PC_OUT, 0);
        check("reset_sp", {{(32-SPW){1'b0}}, sp}, 0);
        check("reset_ovf", {31'd0, overflow}, 0);
        check("reset_unf", {31'd0, underflow}, 0);
        op(3'd1, 0, 0, 0, 1'b1);
        check("stall_inc_pc", PC_OUT, 0);

        // 2. INC x3, JUMP, BREL negative
        op(3'd1, 0); check("inc1", PC_OUT, 1);
        op(3'd1, 0); check("inc2", PC_OUT, 2);
        op(3'd1, 0); check("inc3", PC_OUT, 3);
        check("inc3_taken", {31'd0, taken}, 0);
        op(3'd2, 100); check("jump", PC_OUT, 100);
        check("jump_taken", {31'd0, taken}, 1);
        op(3'd3, 32'hFFFF_FFFC); check("brel_neg", PC_OUT, 96);
        check("brel_taken", {31'd0, taken}, 1);

        // 3. conditional branches
        op(3'd2, 10);
        op(3'd4, 6, 3'd0, 4'b0100); check("bcond_eq_pc", PC_OUT, 16);
        check("bcond_eq_taken", {31'd0, taken}, 1);
        op(3'd4, 6, 3'd7, 4'b1000); check("bcond_ge_pc", PC_OUT, 17);
        check("bcond_ge_taken", {31'd0, taken}, 0);

        // 4. nested CALL/RET, with a stalled RET in between
        op(3'd2, 20);
        op(3'd5, 200); check("call1_pc", PC_OUT, 200); check("call1_sp", sp, 1);
        op(3'd5, 300); check("call2_pc", PC_OUT, 300); check("call2_sp", sp, 2);
        op(3'd6, 0, 0, 0, 1'b1);
        check("stall_ret_pc", PC_OUT, 300); check("stall_ret_sp", sp, 2);
        check("stall_taken_hold", {31'd0, taken}, 1);
        op(3'd6, 0); check("ret1_pc", PC_OUT, 201); check("ret1_sp", sp, 1);
        op(3'd6, 0); check("ret2_pc", PC_OUT, 21); check("ret2_sp", sp, 0);

        // 5. overflow and underflow
        op(3'd5, 1000); op(3'd5, 2000); op(3'd5, 3000); op(3'd5, 4000);
        check("ovf_pre", {31'd0, overflow}, 0);
        op(3'd5, 5000);
        check("ovf_pc", PC_OUT, 5000); check("ovf_sp", sp, 4);
        check("ovf_flag", {31'd0, overflow}, 1);
        op(3'd6, 0); check("pop1", PC_OUT, 3001);
        op(3'd6, 0); check("pop2", PC_OUT, 2001);
        op(3'd6, 0); check("pop3", PC_OUT, 1001);
        op(3'd6, 0); check("pop4", PC_OUT, 22);
        op(3'd6, 0); check("unf_pc", PC_OUT, 22);
        check("unf_flag", {31'd0, underflow}, 1);
        check("unf_taken", {31'd0, taken}, 0);
        op(3'd7, 77); check("rsvd_hold", PC_OUT, 22);

        // 6. wrap-around and async reset mid-CALL sequence
        op(3'd2, 32'hFFFF_FFFF);
        op(3'd1, 0); check("wrap_inc", PC_OUT, 0);
        op(3'd5, 50); op(3'd5, 60);
        @(negedge clock);
        PS = 3'd5; PC_IN = 70;
        #2;
        reset = 1'b0;
        #2;
        check("async_rst_pc", PC_OUT, 0);
        check("async_rst_sp", {{(32-SPW){1'b0}}, sp}, 0);
        check("async_rst_ovf", {31'd0, overflow}, 0);
        @(negedge clock);
        PS = 3'd0;
        reset = 1'b1;
        op(3'd6, 0); check("post_rst_ret_pc", PC_OUT, 0);
        check("post_rst_unf", {31'd0, underflow}, 1);

        repeat (2) @(posedge clock);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
